ysyx_23060332_wbu: RTL and testbench
====================================

YSYX_23060332_WBU -- requirements
Module: ysyx_23060332_wbu

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of every data bus.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port issue_valid  in  1  IDU issues an instruction this cycle.
REQ-005 SHALL have port issue_rd  in  5  destination register of the issued instruction.
REQ-006 SHALL have port exu_valid  in  1  EXU result available.
REQ-007 SHALL have port exu_ready  out  1  WBU accepts the EXU result.
REQ-008 SHALL have port exu_rd  in  5  EXU destination register.
REQ-009 SHALL have port exu_data  in  XLEN  EXU result.
REQ-010 SHALL have port lsu_valid  in  1  load data available.
REQ-011 SHALL have port lsu_ready  out  1  WBU accepts the load data.
REQ-012 SHALL have port lsu_rd  in  5  load destination register.
REQ-013 SHALL have port lsu_data  in  XLEN  load data.
REQ-014 SHALL have port reg_wen  out  1  register-file write enable.
REQ-015 SHALL have port waddr  out  5  register-file write address.
REQ-016 SHALL have port wdata  out  XLEN  register-file write data.
REQ-017 SHALL have port raddr1  in  5  IDU source register 1.
REQ-018 SHALL have port raddr2  in  5  IDU source register 2.
REQ-019 SHALL have port raw_stall  out  1  IDU must hold issue (RAW or WAW hazard).
REQ-020 SHALL have port busy  out  32  per-register pending-write scoreboard.

Function
REQ-021 SHALL accept a source when valid and ready are both high at a rising clk edge.
REQ-022 SHALL drive lsu_ready = 1 always and exu_ready = !lsu_valid (LSU has fixed priority).
REQ-023 SHALL register the accepted source: reg_wen, waddr, wdata valid in the cycle after acceptance; exactly one cycle latency.
REQ-024 SHALL drive reg_wen = 0 in the cycle after an acceptance with rd = 0; waddr/wdata then hold their previous values.
REQ-025 SHALL drive reg_wen = 0 in any cycle following no acceptance; reg_wen never high two cycles for one acceptance.
REQ-026 SHALL sustain one writeback per cycle under back-to-back acceptances.
REQ-027 SHALL set busy[issue_rd] at the edge where issue_valid = 1, issue_rd != 0 and raw_stall = 0.
REQ-028 SHALL clear busy[waddr] at the edge ending a cycle with reg_wen = 1 (same edge as the register-file write).
REQ-029 SHALL let set win over clear when both target the same register at the same edge.
REQ-030 SHALL hold busy[0] = 0 permanently.
REQ-031 SHALL compute raw_stall combinationally = busy[raddr1] | busy[raddr2] | (issue_valid & busy[issue_rd]).
REQ-032 SHALL not bypass: a register being written this cycle still reads as busy until the following cycle.
REQ-033 SHALL ignore issue_valid while raw_stall = 1 (no scoreboard change).
REQ-034 SHALL treat exu_valid/lsu_valid as held by the source until accepted; data sampled only at acceptance.

Reset
REQ-035 SHALL, while rst = 1 at a rising edge, clear busy to 0, reg_wen to 0, waddr to 0, wdata to 0.
REQ-036 SHALL discard any acceptance or issue coinciding with reset; no write is emitted afterwards.
REQ-037 SHALL hold exu_ready/lsu_ready at their combinational values during reset, with acceptances ignored.

Verification
REQ-038 SHALL pass: issue rd=5, next cycle exu_valid rd=5 data=0x1234 -> reg_wen=1 waddr=5 wdata=0x1234 one cycle later; busy[5] 1 then 0.
REQ-039 SHALL pass: exu_valid and lsu_valid same cycle (rd=3 0xAA, rd=4 0xBB) -> exu_ready=0; write x4=0xBB, then x3=0xAA next cycle.
REQ-040 SHALL pass: busy[7]=1, raddr1=7 -> raw_stall=1; stays 1 through the reg_wen cycle, 0 the cycle after.
REQ-041 SHALL pass: lsu_valid rd=0 data=0xFFFF -> lsu_ready=1, reg_wen stays 0, busy unchanged.
REQ-042 SHALL pass: writeback x9 and issue rd=9 at same edge -> busy[9]=1 afterwards.
REQ-043 SHALL pass: rst=1 with busy=0x0000_0F00 and pending acceptance -> busy=0, reg_wen=0 next cycle, no write.

Source files
------------

// File: rtl/ysyx_23060332_wbu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060332_wbu
// Description : Writeback unit. Merges result streams from the EXU and the LSU
//               into a single registered register-file write port, and keeps a
//               per-register pending-write scoreboard used by the IDU to stall
//               on RAW/WAW hazards.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   issue_valid / issue_rd   instruction issued by the IDU this cycle
//   exu_valid/ready/rd/data  EXU result handshake (lower priority)
//   lsu_valid/ready/rd/data  LSU load-data handshake (fixed priority)
//   reg_wen/waddr/wdata      register-file write port, one cycle after accept
//   raddr1 / raddr2          IDU source registers checked against scoreboard
//   raw_stall                IDU must hold its issue this cycle
//   busy                     scoreboard, bit n = write to xn still pending
//
// Revision    : 1.0  initial release
// ============================================================================
module ysyx_23060332_wbu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,

  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [4:0]      exu_rd,
  input  logic [XLEN-1:0] exu_data,

  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,

  output logic            reg_wen,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata,

  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic            raw_stall,
  output logic [31:0]     busy
);

  logic            r_wen;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic [31:0]     r_busy;

  logic            w_lsu_acc;
  logic            w_exu_acc;
  logic            w_acc;
  logic [4:0]      w_acc_rd;
  logic [XLEN-1:0] w_acc_data;
  logic            w_issue_set;
  logic [31:0]     w_set_mask;
  logic [31:0]     w_clr_mask;
  logic [31:0]     w_busy_next;

  // LSU always wins; the EXU waits (holding its valid) whenever a load is
  // presented in the same cycle.
  assign lsu_ready = 1'b1;
  assign exu_ready = ~lsu_valid;

  assign w_lsu_acc  = lsu_valid;
  assign w_exu_acc  = exu_valid & ~lsu_valid;
  assign w_acc      = w_lsu_acc | w_exu_acc;
  assign w_acc_rd   = w_lsu_acc ? lsu_rd   : exu_rd;
  assign w_acc_data = w_lsu_acc ? lsu_data : exu_data;

  // No bypass: a register being written this cycle still reads busy, so the
  // stall only drops once the scoreboard bit has actually been cleared.
  assign raw_stall = r_busy[raddr1] | r_busy[raddr2] |
                     (issue_valid & r_busy[issue_rd]);

  assign w_issue_set = issue_valid & (issue_rd != 5'd0) & ~raw_stall;
  assign w_set_mask  = w_issue_set ? (32'd1 << issue_rd) : 32'd0;
  assign w_clr_mask  = r_wen ? (32'd1 << r_waddr) : 32'd0;

  // Set is applied after clear so a same-register issue beats a writeback.
  // Bit 0 is forced low because x0 is never a real destination.
  assign w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= '0;
      r_busy  <= 32'd0;
    end else begin
      r_busy <= w_busy_next;
      // A write to x0 is swallowed; address/data keep their previous values.
      if (w_acc && (w_acc_rd != 5'd0)) begin
        r_wen   <= 1'b1;
        r_waddr <= w_acc_rd;
        r_wdata <= w_acc_data;
      end else begin
        r_wen   <= 1'b0;
      end
    end
  end

  assign reg_wen = r_wen;
  assign waddr   = r_waddr;
  assign wdata   = r_wdata;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060332_wbu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060332_wbu
// Description : Directed self-checking bench for ysyx_23060332_wbu.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ysyx_23060332_wbu;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            exu_valid;
  logic            exu_ready;
  logic [4:0]      exu_rd;
  logic [XLEN-1:0] exu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            reg_wen;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;
  logic [4:0]      raddr1;
  logic [4:0]      raddr2;
  logic            raw_stall;
  logic [31:0]     busy;

  int n_tests;
  int n_fail;

  ysyx_23060332_wbu #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .exu_valid  (exu_valid),
    .exu_ready  (exu_ready),
    .exu_rd     (exu_rd),
    .exu_data   (exu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .reg_wen    (reg_wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .raw_stall  (raw_stall),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; registered outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    issue_valid = 1'b0; issue_rd = 5'd0;
    exu_valid = 1'b0; exu_rd = 5'd0; exu_data = '0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = '0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    tick();
    tick();

    // Reset state
    check("rst_wen",   32'(reg_wen), 32'd0);
    check("rst_waddr", 32'(waddr),   32'd0);
    check("rst_wdata", wdata,        32'd0);
    check("rst_busy",  busy,         32'd0);
    check("rst_lsu_ready", 32'(lsu_ready), 32'd1);
    rst = 1'b0;

    // Issue x5, then EXU writes x5 = 0x1234
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    check("t1_busy_set", busy, 32'h0000_0020);
    issue_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234;
    #1;
    check("t1_exu_ready", 32'(exu_ready), 32'd1);
    tick();
    exu_valid = 1'b0;
    check("t1_wen",   32'(reg_wen), 32'd1);
    check("t1_waddr", 32'(waddr),   32'd5);
    check("t1_wdata", wdata,        32'h1234);
    check("t1_busy_during_wb", busy, 32'h0000_0020);
    tick();
    check("t1_wen_once", 32'(reg_wen), 32'd0);
    check("t1_busy_clr", busy,         32'd0);

    // EXU and LSU together: LSU first, EXU held and accepted next cycle
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hAA;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hBB;
    #1;
    check("t2_exu_ready_blocked", 32'(exu_ready), 32'd0);
    check("t2_lsu_ready",         32'(lsu_ready), 32'd1);
    tick();
    lsu_valid = 1'b0;
    check("t2_wen_a",   32'(reg_wen), 32'd1);
    check("t2_waddr_a", 32'(waddr),   32'd4);
    check("t2_wdata_a", wdata,        32'hBB);
    #1;
    check("t2_exu_ready_free", 32'(exu_ready), 32'd1);
    tick();
    exu_valid = 1'b0;
    check("t2_wen_b",   32'(reg_wen), 32'd1);
    check("t2_waddr_b", 32'(waddr),   32'd3);
    check("t2_wdata_b", wdata,        32'hAA);
    tick();
    check("t2_wen_idle", 32'(reg_wen), 32'd0);

    // RAW stall on x7; an issue while stalled must not touch the scoreboard
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_rd = 5'd8; raddr1 = 5'd7;
    #1;
    check("t3_stall_raddr1", 32'(raw_stall), 32'd1);
    tick();
    check("t3_stalled_issue_ignored", busy, 32'h0000_0080);
    raddr1 = 5'd0; issue_rd = 5'd7;
    #1;
    check("t3_stall_waw", 32'(raw_stall), 32'd1);
    issue_valid = 1'b0; raddr1 = 5'd7;
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h77;
    tick();
    exu_valid = 1'b0;
    check("t3_wen",   32'(reg_wen),   32'd1);
    check("t3_waddr", 32'(waddr),     32'd7);
    check("t3_stall_in_wb", 32'(raw_stall), 32'd1);
    tick();
    check("t3_stall_after", 32'(raw_stall), 32'd0);
    check("t3_busy_clr",    busy,           32'd0);
    raddr1 = 5'd0;

    // Load to x0: accepted, no write, previous address/data retained
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF;
    #1;
    check("t4_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    lsu_valid = 1'b0;
    check("t4_wen",        32'(reg_wen), 32'd0);
    check("t4_waddr_hold", 32'(waddr),   32'd7);
    check("t4_wdata_hold", wdata,        32'h77);
    check("t4_busy",       busy,         32'd0);

    // Untracked write to x9 with an issue of x9 at the same edge: set wins
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99;
    tick();
    exu_valid = 1'b0;
    check("t5_wen",   32'(reg_wen), 32'd1);
    check("t5_waddr", 32'(waddr),   32'd9);
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    check("t5_no_stall", 32'(raw_stall), 32'd0);
    tick();
    issue_valid = 1'b0;
    check("t5_set_wins", busy, 32'h0000_0200);
    raddr2 = 5'd9;
    #1;
    check("t5_stall_raddr2", 32'(raw_stall), 32'd1);
    raddr2 = 5'd0;

    // Build busy = 0xF00, then reset with pending acceptance and issue
    issue_valid = 1'b1; issue_rd = 5'd8;
    tick();
    issue_rd = 5'd10;
    tick();
    issue_rd = 5'd11;
    tick();
    issue_valid = 1'b0;
    check("t6_busy_f00", busy, 32'h0000_0F00);
    rst = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd13;
    exu_valid = 1'b1; exu_rd = 5'd12; exu_data = 32'hCC;
    lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_data = 32'hDD;
    #1;
    check("t6_exu_ready_in_rst", 32'(exu_ready), 32'd0);
    check("t6_lsu_ready_in_rst", 32'(lsu_ready), 32'd1);
    tick();
    rst = 1'b0;
    issue_valid = 1'b0; exu_valid = 1'b0; lsu_valid = 1'b0;
    check("t6_busy_rst",  busy,         32'd0);
    check("t6_wen_rst",   32'(reg_wen), 32'd0);
    check("t6_waddr_rst", 32'(waddr),   32'd0);
    check("t6_wdata_rst", wdata,        32'd0);
    tick();
    check("t6_no_write_after", 32'(reg_wen), 32'd0);
    check("t6_busy_still_0",   busy,         32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
